// File: rtl/keyseq_pkg.sv
// Shared state type and default sizing for the round-key sequencer.
package keyseq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } keyseq_state_t;

  localparam int KEYSEQ_KEY_W      = 48;
  localparam int KEYSEQ_NUM_ROUNDS = 16;

endpackage

// File: rtl/key_bank.sv
// Round-key register bank: parallel load of a full schedule, zeroize strobe,
// and one indexed read port.
module key_bank #(
  parameter int KEY_W      = 48,
  parameter int NUM_ROUNDS = 16,
  parameter int IDX_W      = $clog2(NUM_ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_load,
  input  logic                        i_zeroize,
  input  logic [NUM_ROUNDS*KEY_W-1:0] i_keys,
  input  logic [IDX_W-1:0]            i_rd_idx,
  output logic [KEY_W-1:0]            o_rd_key
);

  logic [KEY_W-1:0] r_bank [NUM_ROUNDS];

  // Round 0 arrives in the most significant slice of the packed schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (i_zeroize) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        r_bank[i] <= '0;
      end
    end else if (i_load) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        r_bank[i] <= i_keys[(NUM_ROUNDS-i)*KEY_W-1 -: KEY_W];
      end
    end
  end

  assign o_rd_key = r_bank[i_rd_idx];

endmodule

// File: rtl/round_key_sequencer.sv
// Round-key sequencer: captures a DES key schedule and issues one key per
// handshake, forward for encrypt, reversed for decrypt. Optional macro
// KEYSEQ_AUTO_ZEROIZE_EN wipes the bank after each completed sequence.
module round_key_sequencer
  import keyseq_pkg::*;
#(
  parameter  int KEY_W      = KEYSEQ_KEY_W,
  parameter  int NUM_ROUNDS = KEYSEQ_NUM_ROUNDS,
  localparam int IDX_W      = $clog2(NUM_ROUNDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic [NUM_ROUNDS*KEY_W-1:0] round_keys_i,
  input  logic                        encrypt_decrypt,
  input  logic                        start_i,
  output logic [KEY_W-1:0]            key_o,
  output logic                        key_valid_o,
  input  logic                        key_ready_i,
  output logic [IDX_W-1:0]            round_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        loaded_o,
  output logic                        done_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  keyseq_state_t    r_state;
  keyseq_state_t    w_stateNext;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cntNext;
  logic [IDX_W-1:0] w_slot;
  logic             r_dir;
  logic             w_dirNext;
  logic             r_loaded;
  logic             w_loadedNext;
  logic             r_done;
  logic             w_doneNext;
  logic             w_bankLoad;
  logic             w_bankZero;
  logic             w_xfer;
  logic             w_last;
  logic [KEY_W-1:0] w_bankKey;

  assign w_last = (r_state == RUN) && (r_cnt == LAST_IDX);
  assign w_xfer = (r_state == RUN) && key_ready_i;
  assign w_slot = r_dir ? (LAST_IDX - r_cnt) : r_cnt;

  key_bank #(
    .KEY_W      (KEY_W),
    .NUM_ROUNDS (NUM_ROUNDS),
    .IDX_W      (IDX_W)
  ) u_key_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_bankLoad),
    .i_zeroize (w_bankZero),
    .i_keys    (round_keys_i),
    .i_rd_idx  (w_slot),
    .o_rd_key  (w_bankKey)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_loaded <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_dir    <= w_dirNext;
      r_loaded <= w_loadedNext;
      r_done   <= w_doneNext;
    end
  end

  // Loads and starts are only honoured in IDLE, so the bank never changes mid-sequence.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_dirNext    = r_dir;
    w_loadedNext = r_loaded;
    w_doneNext   = 1'b0;
    w_bankLoad   = 1'b0;
    w_bankZero   = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_i) begin
          w_bankLoad   = 1'b1;
          w_loadedNext = 1'b1;
        end else if (start_i && r_loaded) begin
          w_dirNext   = encrypt_decrypt;
          w_cntNext   = '0;
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (w_xfer) begin
          if (w_last) begin
            w_stateNext = IDLE;
            w_cntNext   = '0;
            w_doneNext  = 1'b1;
`ifdef KEYSEQ_AUTO_ZEROIZE_EN
            w_bankZero   = 1'b1;
            w_loadedNext = 1'b0;
`else
            w_bankZero   = 1'b0;
`endif
          end else begin
            w_cntNext = r_cnt + IDX_W'(1);
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign key_o       = (r_state == RUN) ? w_bankKey : '0;
  assign key_valid_o = (r_state == RUN);
  assign busy_o      = (r_state == RUN);
  assign round_o     = r_cnt;
  assign last_o      = w_last;
  assign loaded_o    = r_loaded;
  assign done_o      = r_done;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Self-checking bench for round_key_sequencer: directed vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_round_key_sequencer;

  localparam int KW = 48;
  localparam int NR = 16;

`ifdef KEYSEQ_AUTO_ZEROIZE_EN
  localparam logic LOADED_AFTER = 1'b0;
`else
  localparam logic LOADED_AFTER = 1'b1;
`endif

  typedef struct packed {
    logic [KW-1:0] key;
    logic          valid;
    logic [3:0]    round;
    logic          last;
    logic          busy;
    logic          loaded;
    logic          done;
  } outs_t;

  typedef struct {
    logic  load;
    logic  start;
    logic  dir;
    logic  ready;
    outs_t exp;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [NR*KW-1:0] roundKeys;
  logic             encDec;
  logic             start;
  logic [KW-1:0]    keyOut;
  logic             keyValid;
  logic             ready;
  logic [3:0]       roundOut;
  logic             lastOut;
  logic             busyOut;
  logic             loadedOut;
  logic             doneOut;

  int total = 0;
  int bad   = 0;

  logic [KW-1:0] tbKeys [NR];
  logic [KW-1:0] mBank  [NR];
  logic [KW-1:0] mQ [$];
  logic          mLoaded;
  logic          mDone;
  vec_t          vecs [$];

  round_key_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_i          (load),
    .round_keys_i    (roundKeys),
    .encrypt_decrypt (encDec),
    .start_i         (start),
    .key_o           (keyOut),
    .key_valid_o     (keyValid),
    .key_ready_i     (ready),
    .round_o         (roundOut),
    .last_o          (lastOut),
    .busy_o          (busyOut),
    .loaded_o        (loadedOut),
    .done_o          (doneOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  function automatic outs_t mk(logic run, logic [KW-1:0] key, logic [3:0] round,
                               logic last, logic loaded, logic done);
    outs_t o;
    o.key    = key;
    o.valid  = run;
    o.round  = round;
    o.last   = last;
    o.busy   = run;
    o.loaded = loaded;
    o.done   = done;
    return o;
  endfunction

  function automatic outs_t dutOuts();
    return {keyOut, keyValid, roundOut, lastOut, busyOut, loadedOut, doneOut};
  endfunction

  // Model: a sequence in flight is just the queue of keys still to hand over.
  function automatic outs_t modelOut();
    outs_t o;
    int    n;
    n = mQ.size();
    o = mk(n > 0, (n > 0) ? mQ[0] : '0, (n > 0) ? 4'(NR - n) : 4'd0,
           n == 1, mLoaded, mDone);
    return o;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NR; i++) mBank[i] = '0;
    mQ.delete();
    mLoaded = 1'b0;
    mDone   = 1'b0;
  endtask

  task automatic modelStep(logic ld, logic st, logic dir, logic rdy);
    logic nd;
    nd = 1'b0;
    if (mQ.size() > 0) begin
      if (rdy) begin
        void'(mQ.pop_front());
        if (mQ.size() == 0) begin
          nd = 1'b1;
`ifdef KEYSEQ_AUTO_ZEROIZE_EN
          for (int i = 0; i < NR; i++) mBank[i] = '0;
          mLoaded = 1'b0;
`endif
        end
      end
    end else if (ld) begin
      for (int i = 0; i < NR; i++) mBank[i] = tbKeys[i];
      mLoaded = 1'b1;
    end else if (st && mLoaded) begin
      for (int i = 0; i < NR; i++) begin
        if (dir) mQ.push_front(mBank[i]);
        else     mQ.push_back(mBank[i]);
      end
    end
    mDone = nd;
  endtask

  task automatic packKeys();
    for (int i = 0; i < NR; i++) roundKeys[(NR-i)*KW-1 -: KW] = tbKeys[i];
  endtask

  task automatic setBaseKeys(logic [KW-1:0] base);
    for (int i = 0; i < NR; i++) tbKeys[i] = base + KW'(i);
    packKeys();
  endtask

  task automatic applyStimulus(logic ld, logic st, logic dir, logic rdy);
    @(negedge clk);
    load   = ld;
    start  = st;
    encDec = dir;
    ready  = rdy;
    @(posedge clk);
    modelStep(ld, st, dir, rdy);
    #1;
  endtask

  task automatic checkOutput(string name, outs_t exp);
    outs_t got;
    got = dutOuts();
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got key=%h v=%b r=%0d l=%b b=%b ld=%b d=%b want key=%h v=%b r=%0d l=%b b=%b ld=%b d=%b",
               name, got.key, got.valid, got.round, got.last, got.busy, got.loaded, got.done,
               exp.key, exp.valid, exp.round, exp.last, exp.busy, exp.loaded, exp.done);
    end
  endtask

  task automatic checkVal(string name, logic [KW-1:0] got, logic [KW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic stepModel(logic ld, logic st, logic dir, logic rdy, string name);
    applyStimulus(ld, st, dir, rdy);
    checkOutput(name, modelOut());
  endtask

  task automatic resetDut(string name);
    load  = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput(name, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles;
    int stalls;
    logic ld;
    logic rdy;
    logic [63:0] rnd;

    rst_n  = 1'b1;
    load   = 1'b0;
    start  = 1'b0;
    encDec = 1'b0;
    ready  = 1'b0;
    setBaseKeys(48'h1000);
    modelReset();
    #2;
    resetDut("resetState");

    // Directed encrypt then decrypt streams, expectations written as constants.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, '0, 4'd0, 1'b0, 1'b1, 1'b0)});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, mk(1'b1, 48'h1000, 4'd0, 1'b0, 1'b1, 1'b0)});
    for (int k = 1; k < NR; k++)
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,
                       mk(1'b1, 48'h1000 + KW'(k), 4'(k), k == NR-1, 1'b1, 1'b0)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, '0, 4'd0, 1'b0, LOADED_AFTER, 1'b1)});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, mk(1'b0, '0, 4'd0, 1'b0, 1'b1, 1'b0)});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, mk(1'b1, 48'h100F, 4'd0, 1'b0, 1'b1, 1'b0)});
    for (int k = 1; k < NR; k++)
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,
                       mk(1'b1, 48'h100F - KW'(k), 4'(k), k == NR-1, 1'b1, 1'b0)});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, '0, 4'd0, 1'b0, LOADED_AFTER, 1'b1)});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].load, vecs[i].start, vecs[i].dir, vecs[i].ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Start issued in the done cycle.
    stepModel(1'b0, 1'b1, 1'b0, 1'b1, "cfgRestart");
`ifdef KEYSEQ_AUTO_ZEROIZE_EN
    checkVal("cfgZeroStart", {46'd0, keyValid, loadedOut}, '0);
`else
    checkVal("cfgRepeatKey", keyOut, 48'h1000);
`endif
    for (int i = 0; i < 20 && busyOut; i++) stepModel(1'b0, 1'b0, 1'b0, 1'b1, "drain");
    checkVal("drainBound", {47'd0, busyOut}, '0);

    // Illegal controls.
    resetDut("resetAgain");
    stepModel(1'b0, 1'b1, 1'b0, 1'b1, "startUnloaded");
    checkVal("startUnloadedValid", {47'd0, keyValid}, '0);
    stepModel(1'b1, 1'b1, 1'b0, 1'b1, "loadStart");
    checkVal("loadStartFlags", {46'd0, loadedOut, keyValid}, 48'd2);
    stepModel(1'b0, 1'b0, 1'b0, 1'b1, "loadStartIdle");

    // Backpressure at round 5, plus a load with new data mid-run.
    stepModel(1'b0, 1'b1, 1'b0, 1'b1, "bpStart");
    cycles = 0;
    stalls = 0;
    for (int i = 0; i < 40 && busyOut; i++) begin
      rdy = 1'b1;
      ld  = 1'b0;
      if (mQ.size() == NR - 5 && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end
      if (mQ.size() == NR - 8) begin
        setBaseKeys(48'h2000);
        ld = 1'b1;
      end
      stepModel(ld, 1'b0, 1'b0, rdy, "bpRun");
      cycles++;
      if (!rdy) checkVal("bpHold", {keyOut[46:0], keyValid}, {47'h1005, 1'b1});
    end
    checkVal("bpCycles", KW'(cycles), KW'(NR + 3));
    setBaseKeys(48'h1000);

`ifdef KEYSEQ_AUTO_ZEROIZE_EN
    checkVal("zeroLoaded", {47'd0, loadedOut}, '0);
    stepModel(1'b1, 1'b0, 1'b0, 1'b1, "reload");
    stepModel(1'b0, 1'b1, 1'b0, 1'b1, "reuseStart");
`else
    stepModel(1'b0, 1'b1, 1'b0, 1'b1, "reuseStart");
    checkVal("oldKeysKept", keyOut, 48'h1000);
`endif

    // Asynchronous reset in the middle of a sequence.
    for (int i = 0; i < 20 && roundOut != 4'd7; i++) stepModel(1'b0, 1'b0, 1'b0, 1'b1, "toRound7");
    checkVal("reachedRound7", {44'd0, roundOut}, 48'd7);
    #2;
    resetDut("midRunReset");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom % 8) == 0;
      if (ld) begin
        for (int j = 0; j < NR; j++) begin
          rnd = {$urandom(), $urandom()};
          tbKeys[j] = rnd[KW-1:0];
        end
        packKeys();
      end
      stepModel(ld, ($urandom % 3) == 0, 1'($urandom % 2), ($urandom % 4) != 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
# round_key_sequencer

Parametrised round-key store and sequencer for the iterative DES datapath. Captures a full key schedule from the key generator in one cycle, then issues one round key per cycle to the round engine over a valid/ready handshake. Issue order is forward for encrypt and reversed for decrypt. It replaces the fully-unrolled combinational key reordering, so one round instance can be reused across all rounds.

## Interface
- `KEY_W`, 48, round-key width in bits.
- `NUM_ROUNDS`, 16, schedule depth; must be ≥2.
- `IDX_W`, `$clog2(NUM_ROUNDS)`, round-index width (derived, not overridden).

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `load_i`  in  1  capture `round_keys_i` into the bank.
- `round_keys_i`  in  NUM_ROUNDS*KEY_W  schedule; round 0 key in the MSB slice `[NUM_ROUNDS*KEY_W-1 -: KEY_W]`, round N-1 in `[KEY_W-1:0]`.
- `encrypt_decrypt`  in  1  0 = encrypt (forward), 1 = decrypt (reverse); sampled on accepted start.
- `start_i`  in  1  begin a key sequence.
- `key_o`  out  KEY_W  current round key.
- `key_valid_o`  out  1  `key_o` valid.
- `key_ready_i`  in  1  engine accepts `key_o`.
- `round_o`  out  IDX_W  logical round number of `key_o` (0..NUM_ROUNDS-1).
- `last_o`  out  1  `key_o` is the final key of the sequence.
- `busy_o`  out  1  sequence in progress.
- `loaded_o`  out  1  bank holds a valid schedule.
- `done_o`  out  1  one-cycle pulse after the final handshake.

## Operation
- FSM states: IDLE and RUN.
- Handshake: a key is transferred when `key_valid_o && key_ready_i`.
- IDLE, `load_i=1` → bank written, `loaded_o←1` next cycle.
- Load has priority: `start_i` in the same cycle as `load_i` is ignored.
- IDLE, `start_i=1`, `loaded_o=1`, `load_i=0` → latch direction, `cnt←0`, go to RUN.
- IDLE, `start_i=1` with `loaded_o=0` → ignored and no state change.
- RUN: `key_valid_o=1`, `round_o=cnt`.
  - Physical slot = `cnt` when direction = 0, else `NUM_ROUNDS-1-cnt`.
  - `last_o = (cnt == NUM_ROUNDS-1)`.
- RUN, handshake with `last_o=0` → `cnt++`.
- RUN, handshake with `last_o=1` → IDLE, `done_o=1` next cycle, `cnt←0`.
- RUN with `key_ready_i=0` → `key_o`, `round_o` and `last_o` hold stable; valid is never withdrawn.
- `load_i` and `start_i` in RUN are ignored. The bank is never modified mid-sequence.
- `encrypt_decrypt` changes during RUN have no effect.
- Asynchronous reset mid-sequence → IDLE immediately, bank cleared, `loaded_o=0`.

## Timing
- Reset values:
  - `key_o=0`, `key_valid_o=0`, `round_o=0`, `last_o=0`.
  - `busy_o=0`, `loaded_o=0`, `done_o=0`.
  - Bank all zero, `cnt=0`, state IDLE.
- Start accepted at edge T → `key_valid_o=1` with the first key from cycle T+1.
- With `key_ready_i` held high, NUM_ROUNDS keys transfer in NUM_ROUNDS consecutive cycles with no bubbles.
- `done_o` is high the cycle after the last handshake. `busy_o` is low the same cycle.
- Earliest restart: `start_i` in the `done_o` cycle is accepted.
- `busy_o = (state == RUN)`.
- `key_o` is a mux of bank registers selected by registered `cnt` and direction. The output has no combinational path from any input.

## Configuration
- `KEYSEQ_AUTO_ZEROIZE_EN` defined:
  - The final handshake clears every bank entry to zero and `loaded_o←0` on the same edge that sets `done_o`.
  - A new `load_i` is required before the next start.
- Not defined:
  - The bank is retained after a sequence, so repeated starts reuse the schedule.
  - Only reset or a new load changes the bank.

## Structure
- Package `keyseq_pkg`:
  - State enum `keyseq_state_t` {IDLE, RUN}.
  - Default constants `KEYSEQ_KEY_W=48`, `KEYSEQ_NUM_ROUNDS=16`.
- Sub-module `key_bank`:
  - NUM_ROUNDS×KEY_W register array with parallel load, zeroize strobe and one indexed read port.
  - Top level holds the FSM, counter, direction latch and handshake.

## Test plan
- Encrypt stream: load key[i]=48'h0000_0000_1000+i; start (`encrypt_decrypt=0`) with ready held high → 16 consecutive keys 0x1000..0x100F, `round_o` 0..15, `last_o` only on 0x100F, `done_o` one cycle later.
- Decrypt stream: same load, `encrypt_decrypt=1` → keys 0x100F..0x1000, `round_o` 0..15, `last_o` on 0x1000.
- Backpressure: drop `key_ready_i` for 3 cycles at `round_o=5` → `key_o` held at 0x1005 with valid high; sequence resumes and completes in 16+3 cycles.
- Illegal controls: start with `loaded_o=0` → no valid. Load and start in the same cycle → only load takes effect. Load in RUN with new data → current sequence still issues the old keys.
- Reset mid-run: assert `rst_n=0` at `round_o=7` → all outputs zero asynchronously and `loaded_o=0`.
- Config: with `KEYSEQ_AUTO_ZEROIZE_EN`, second start after done → ignored and `loaded_o=0`. Without it, second start → full repeat of 0x1000..0x100F.
